// File: rtl/playfield_render_pipe.sv
// Playfield renderer: maps each VGA pixel onto a playfield tile and produces its colour
// two cycles later, with an optional inter-tile border and a line-clear flash animation.

package DisplayPkg;
    typedef enum logic [2:0] {
        TILE_BLANK = 3'd0,
        TILE_I     = 3'd1,
        TILE_O     = 3'd2,
        TILE_T     = 3'd3,
        TILE_J     = 3'd4,
        TILE_L     = 3'd5,
        TILE_S     = 3'd6,
        TILE_Z     = 3'd7
    } tile_type_t;

    localparam logic [23:0] TILE_COLOR        = 24'h101010;
    localparam logic [23:0] TETROMINO_I_COLOR = 24'h00FFFF;
    localparam logic [23:0] TETROMINO_O_COLOR = 24'hFFFF00;
    localparam logic [23:0] TETROMINO_T_COLOR = 24'h800080;
    localparam logic [23:0] TETROMINO_J_COLOR = 24'h0000FF;
    localparam logic [23:0] TETROMINO_L_COLOR = 24'hFFA500;
    localparam logic [23:0] TETROMINO_S_COLOR = 24'h00FF00;
    localparam logic [23:0] TETROMINO_Z_COLOR = 24'hFF0000;
endpackage

module playfield_render_pipe
    import DisplayPkg::*;
#(
    parameter int          ROWS          = 20,
    parameter int          COLS          = 10,
    parameter int          TILE_W        = 20,
    parameter int          TILE_H        = 20,
    parameter int          HSTART        = 220,
    parameter int          VSTART        = 40,
    parameter int          BORDER        = 1,
    parameter logic [23:0] BORDER_COLOR  = 24'h202020,
    parameter logic [23:0] FLASH_COLOR   = 24'hFFFFFF,
    parameter int          FLASH_FRAMES  = 4,
    parameter int          FLASH_TOGGLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       VGA_row,
    input  logic [9:0]       VGA_col,
    input  tile_type_t       tile_type [ROWS][COLS],
    input  logic             frame_start,
    input  logic             clear_req,
    input  logic [ROWS-1:0]  clear_rows,
    output logic [23:0]      output_color,
    output logic             active,
    output logic             clear_busy,
    output logic             clear_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int XW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int YW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int TW = $clog2(2 * FLASH_TOGGLES);

    localparam logic [10:0] ROW_LO = 11'(VSTART);
    localparam logic [10:0] ROW_HI = 11'(VSTART + ROWS * TILE_H);
    localparam logic [10:0] COL_LO = 11'(HSTART);
    localparam logic [10:0] COL_HI = 11'(HSTART + COLS * TILE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLASH = 2'd1,
        ST_DONE  = 2'd2
    } flash_state_t;

    // Stage 1 signals
    logic [10:0]   rowWide, colWide, rowRel, colRel;
    logic [10:0]   yTmp, xTmp;
    logic          inField_d, inField_q;
    logic [RW-1:0] rowIdx_d, rowIdx_q;
    logic [CW-1:0] colIdx_d, colIdx_q;
    logic [YW-1:0] yOff_d, yOff_q;
    logic [XW-1:0] xOff_d, xOff_q;

    // Stage 2 signals
    logic          borderHit, flashHit;
    logic [23:0]   color_d, color_q;
    logic          active_q;

    // Flash animation signals
    flash_state_t  state_d, state_q;
    logic          busy_d, busy_q, done_d, done_q;
    logic [ROWS-1:0] mask_q;
    logic          phaseOn_q;
    logic [FW-1:0] frame_q;
    logic [TW-1:0] tog_q;
    logic          lastFrame, lastToggle;

    assign rowWide = {1'b0, VGA_row};
    assign colWide = {1'b0, VGA_col};
    assign rowRel  = rowWide - ROW_LO;
    assign colRel  = colWide - COL_LO;

    // Field test plus tile index/offset by walking a compare chain over the tile boundaries
    always_comb begin
        inField_d = (rowWide >= ROW_LO) && (rowWide < ROW_HI) &&
                    (colWide >= COL_LO) && (colWide < COL_HI);
        rowIdx_d  = '0;
        colIdx_d  = '0;
        yTmp      = rowRel;
        xTmp      = colRel;
        for (int i = 1; i < ROWS; i++) begin
            if (rowRel >= 11'(i * TILE_H)) begin
                rowIdx_d = RW'(i);
                yTmp     = rowRel - 11'(i * TILE_H);
            end
        end
        for (int j = 1; j < COLS; j++) begin
            if (colRel >= 11'(j * TILE_W)) begin
                colIdx_d = CW'(j);
                xTmp     = colRel - 11'(j * TILE_W);
            end
        end
        yOff_d = yTmp[YW-1:0];
        xOff_d = xTmp[XW-1:0];
    end

    // Stage 1 register: tile coordinates of the incoming pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            inField_q <= 1'b0;
            rowIdx_q  <= '0;
            colIdx_q  <= '0;
            yOff_q    <= '0;
            xOff_q    <= '0;
        end else begin
            inField_q <= inField_d;
            rowIdx_q  <= rowIdx_d;
            colIdx_q  <= colIdx_d;
            yOff_q    <= yOff_d;
            xOff_q    <= xOff_d;
        end
    end

    // Colour selection: border beats flash, flash beats tile contents
    always_comb begin
        borderHit = (BORDER > 0) &&
                    ((32'(xOff_q) >= 32'(TILE_W - BORDER)) ||
                     (32'(yOff_q) >= 32'(TILE_H - BORDER)));
        flashHit  = (state_q == ST_FLASH) && phaseOn_q && mask_q[rowIdx_q];
        color_d   = 24'h000000;
        if (inField_q) begin
            if (borderHit) begin
                color_d = BORDER_COLOR;
            end else if (flashHit) begin
                color_d = FLASH_COLOR;
            end else begin
                case (tile_type[rowIdx_q][colIdx_q])
                    TILE_I:  color_d = TETROMINO_I_COLOR;
                    TILE_O:  color_d = TETROMINO_O_COLOR;
                    TILE_T:  color_d = TETROMINO_T_COLOR;
                    TILE_J:  color_d = TETROMINO_J_COLOR;
                    TILE_L:  color_d = TETROMINO_L_COLOR;
                    TILE_S:  color_d = TETROMINO_S_COLOR;
                    TILE_Z:  color_d = TETROMINO_Z_COLOR;
                    default: color_d = TILE_COLOR;
                endcase
            end
        end
    end

    // Stage 2 register: final pixel colour and in-field flag
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q  <= 24'h000000;
            active_q <= 1'b0;
        end else begin
            color_q  <= color_d;
            active_q <= inField_q;
        end
    end

    assign lastFrame  = (frame_q == FW'(FLASH_FRAMES - 1));
    assign lastToggle = (tog_q == TW'(2 * FLASH_TOGGLES - 1));

    // Flash FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flash FSM next state: an empty mask skips straight to the completion pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = (|clear_rows) ? ST_FLASH : ST_DONE;
                end
            end
            ST_FLASH: begin
                if (frame_start && lastFrame && lastToggle) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Flash FSM outputs, decoded from the upcoming state so they register alongside it
    always_comb begin
        busy_d = (state_d == ST_FLASH);
        done_d = (state_d == ST_DONE);
    end

    // Registered busy/done so downstream logic sees glitch-free flags
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Row mask, phase and frame/toggle counters driving the animation
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '0;
            phaseOn_q <= 1'b0;
            frame_q   <= '0;
            tog_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req && (|clear_rows)) begin
                        mask_q    <= clear_rows;
                        phaseOn_q <= 1'b1;
                        frame_q   <= '0;
                        tog_q     <= '0;
                    end
                end
                ST_FLASH: begin
                    if (frame_start) begin
                        if (lastFrame) begin
                            frame_q   <= '0;
                            phaseOn_q <= ~phaseOn_q;
                            if (!lastToggle) begin
                                tog_q <= tog_q + TW'(1);
                            end
                        end else begin
                            frame_q <= frame_q + FW'(1);
                        end
                    end
                end
                default: begin
                    mask_q    <= '0;
                    phaseOn_q <= 1'b0;
                    frame_q   <= '0;
                    tog_q     <= '0;
                end
            endcase
        end
    end

    assign output_color = color_q;
    assign active       = active_q;
    assign clear_busy   = busy_q;
    assign clear_done   = done_q;

endmodule
